// File: rtl/angle_pkg.sv
// Shared definitions for the angle sin/cos sequencer: float widths and FSM states.
package angle_pkg;

    localparam int EXP_LEN_DEF      = 8;
    localparam int MANTISSA_LEN_DEF = 23;
    localparam int NUM_ANGLE_DEF    = 22;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_WRITE  = 3'd4
    } angle_state_e;

endpackage

// File: rtl/angle_sincos_wrapper.sv
// Walks the normalized-angle memory in ascending order, hands each angle to the
// shared external sin/cos unit and writes the cos/sin results back by address.
//
// state  | meaning
// IDLE   | index parked at 0, waiting for start_angle_sincos
// READ   | read address = index presented to the angle memory
// LAUNCH | angle memory data valid; trig_start pulse, angle forwarded to unit
// WAIT   | holding the angle operand until trig_ready
// WRITE  | both result memories written at index; advance or finish
module angle_sincos_wrapper
    import angle_pkg::*;
#(
    parameter int EXP_LEN      = EXP_LEN_DEF,
    parameter int MANTISSA_LEN = MANTISSA_LEN_DEF,
    parameter int NUM_ANGLE    = NUM_ANGLE_DEF,
    localparam int W           = EXP_LEN + MANTISSA_LEN + 1,
    localparam int AW          = (NUM_ANGLE > 1) ? $clog2(NUM_ANGLE) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start_angle_sincos,
    output logic [AW-1:0] mem_angle_combination_value_read_addr,
    input  logic [W-1:0]  mem_angle_combination_value_data_out,
    output logic          trig_start,
    output logic [W-1:0]  trig_angle,
    input  logic          trig_ready,
    input  logic [W-1:0]  trig_cos,
    input  logic [W-1:0]  trig_sin,
    output logic [AW-1:0] mem_cos_write_addr,
    output logic [AW-1:0] mem_sin_write_addr,
    output logic [W-1:0]  mem_cos_data_in,
    output logic [W-1:0]  mem_sin_data_in,
    output logic          mem_cos_write_en,
    output logic          mem_sin_write_en,
    output logic          angle_sincos_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_ANGLE - 1);

    angle_state_e  state_q;
    logic [AW-1:0] index_q;
    logic          trig_start_q;
    logic [W-1:0]  trig_angle_q;
    logic [W-1:0]  cos_q;
    logic [W-1:0]  sin_q;
    logic          wr_en_q;
    logic          done_q;

    // Sequencer: one angle per READ/LAUNCH/WAIT/WRITE pass; pulses are
    // registered so each is high during exactly the state it belongs to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            trig_start_q <= 1'b0;
            trig_angle_q <= '0;
            cos_q        <= '0;
            sin_q        <= '0;
            wr_en_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            trig_start_q <= 1'b0;
            wr_en_q      <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    index_q <= '0;
                    if (start_angle_sincos) begin
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    trig_start_q <= 1'b1;
                    state_q      <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    trig_angle_q <= mem_angle_combination_value_data_out;
                    state_q      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (trig_ready) begin
                        cos_q   <= trig_cos;
                        sin_q   <= trig_sin;
                        wr_en_q <= 1'b1;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (index_q == LAST_IDX) begin
                        index_q <= '0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        index_q <= index_q + 1'b1;
                        state_q <= ST_READ;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The angle memory answers one cycle after READ, i.e. in LAUNCH, so the
    // operand is forwarded straight through during the trig_start cycle and
    // taken from the captured copy for the rest of the handshake.
    always_comb begin
        trig_angle = trig_angle_q;
        if (state_q == ST_LAUNCH) begin
            trig_angle = mem_angle_combination_value_data_out;
        end
    end

    assign mem_angle_combination_value_read_addr = index_q;
    assign trig_start         = trig_start_q;
    assign mem_cos_write_addr = index_q;
    assign mem_sin_write_addr = index_q;
    assign mem_cos_data_in    = cos_q;
    assign mem_sin_data_in    = sin_q;
    assign mem_cos_write_en   = wr_en_q;
    assign mem_sin_write_en   = wr_en_q;
    assign angle_sincos_done  = done_q;

endmodule

// File: tb/tb_angle_sincos_wrapper.sv
// Scoreboard bench for angle_sincos_wrapper with an angle memory model and a
// latency-programmable sin/cos unit model.
module tb_angle_sincos_wrapper;

    localparam int NUM = 22;

    logic        clk;
    logic        reset;
    logic        start;
    logic [4:0]  read_addr;
    logic [31:0] mem_dout;
    logic        trig_start;
    logic [31:0] trig_angle;
    logic        trig_ready;
    logic [31:0] trig_cos;
    logic [31:0] trig_sin;
    logic [4:0]  cos_waddr;
    logic [4:0]  sin_waddr;
    logic [31:0] cos_din;
    logic [31:0] sin_din;
    logic        cos_we;
    logic        sin_we;
    logic        done;

    angle_sincos_wrapper dut (
        .clock                                 (clk),
        .reset                                 (reset),
        .start_angle_sincos                    (start),
        .mem_angle_combination_value_read_addr (read_addr),
        .mem_angle_combination_value_data_out  (mem_dout),
        .trig_start                            (trig_start),
        .trig_angle                            (trig_angle),
        .trig_ready                            (trig_ready),
        .trig_cos                              (trig_cos),
        .trig_sin                              (trig_sin),
        .mem_cos_write_addr                    (cos_waddr),
        .mem_sin_write_addr                    (sin_waddr),
        .mem_cos_data_in                       (cos_din),
        .mem_sin_data_in                       (sin_din),
        .mem_cos_write_en                      (cos_we),
        .mem_sin_write_en                      (sin_we),
        .angle_sincos_done                     (done)
    );

    typedef struct {
        int          addr;
        logic [31:0] c;
        logic [31:0] s;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          done_exp_q[$];
    logic [31:0] angle_tab[NUM];
    logic [31:0] cos_tab[NUM];
    logic [31:0] sin_tab[NUM];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          n_lat    = 5;
    bit          spur_en  = 0;
    bit          spur_idle = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read angle memory
    always @(posedge clk) mem_dout <= angle_tab[read_addr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] cos_of(input logic [31:0] a);
        for (int i = 0; i < NUM; i++) if (angle_tab[i] == a) return cos_tab[i];
        return 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] sin_of(input logic [31:0] a);
        for (int i = 0; i < NUM; i++) if (angle_tab[i] == a) return sin_tab[i];
        return 32'hDEADBEEF;
    endfunction

    task automatic push_run(input int t_read, input int n, input int upto, input bit with_done);
        exp_t e;
        for (int k = 0; k < upto; k++) begin
            e.addr = k;
            e.c    = cos_tab[k];
            e.s    = sin_tab[k];
            e.cyc  = t_read + k * (3 + n) + n + 2;
            exp_q.push_back(e);
        end
        if (with_done) done_exp_q.push_back(t_read + NUM * (3 + n));
    endtask

    task automatic wait_drain(input int budget, input string nm);
        int i;
        i = 0;
        while ((exp_q.size() != 0 || done_exp_q.size() != 0) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk(nm, (exp_q.size() == 0 && done_exp_q.size() == 0), 1);
    endtask

    // sin/cos unit model: answers N cycles after trig_start, plus optional
    // spurious trig_ready pulses carrying garbage results
    initial begin
        int          cnt;
        bit          busy;
        bit          prev_we;
        logic [31:0] ang;
        cnt = 0; busy = 0; prev_we = 0; ang = 0;
        trig_ready = 0; trig_cos = 0; trig_sin = 0;
        forever begin
            @(negedge clk);
            trig_ready = 0; trig_cos = 0; trig_sin = 0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    busy = 0;
                    trig_ready = 1;
                    trig_cos = cos_of(ang);
                    trig_sin = sin_of(ang);
                end
            end
            if (trig_start) begin
                busy = 1; cnt = n_lat; ang = trig_angle;
            end
            if (spur_idle || (spur_en && (trig_start || prev_we))) begin
                trig_ready = 1;
                trig_cos = 32'hBAD0BAD0;
                trig_sin = 32'hBAD1BAD1;
            end
            prev_we = cos_we;
        end
    end

    // monitor: pops expected writes/done pulses whenever the DUT presents them
    always @(negedge clk) begin
        if (!reset) begin
            if (cos_we || sin_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {27'd0, cos_waddr}, 64'hFFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", {27'd0, cos_waddr}, e.addr);
                    chk("sin_addr_eq", {27'd0, sin_waddr}, e.addr);
                    chk("cos_data", cos_din, e.c);
                    chk("sin_data", sin_din, e.s);
                    chk("we_pair", {cos_we, sin_we}, 2'b11);
                    chk("we_vs_trig_start", trig_start, 0);
                    chk("write_cycle", cyc, e.cyc);
                end
            end
            if (done) begin
                if (done_exp_q.size() == 0) chk("unexpected_done", 1, 0);
                else chk("done_cycle", cyc, done_exp_q.pop_front());
            end
        end
    end

    initial begin
        int  t_launch;
        int  dcnt;
        bit  found;

        for (int i = 0; i < NUM; i++) begin
            angle_tab[i] = 32'h3F800000 + i * 32'h00100000;
            cos_tab[i]   = 32'h3F000000 + i;
            sin_tab[i]   = 32'h3E000000 + (i << 4);
        end
        cos_tab[0] = 32'h3F0A5140;
        sin_tab[0] = 32'h3F576AA4;

        reset = 1; start = 0;
        repeat (3) @(negedge clk);
        chk("rst_state", dut.state_q, 0);
        chk("rst_read_addr", read_addr, 0);
        chk("rst_trig_start", trig_start, 0);
        chk("rst_trig_angle", trig_angle, 0);
        chk("rst_we", {cos_we, sin_we}, 0);
        chk("rst_waddr", {cos_waddr, sin_waddr}, 0);
        chk("rst_data", {cos_din, sin_din}, 0);
        chk("rst_done", done, 0);
        reset = 0;

        // trig_ready while idle must not produce writes
        spur_idle = 1;
        repeat (3) @(negedge clk);
        spur_idle = 0;
        @(negedge clk);
        chk("idle_ready_we", cos_we, 0);
        chk("idle_ready_read_addr", read_addr, 0);

        // run A: N=5, spurious ready in READ/LAUNCH, start toggled mid-run
        n_lat = 5; spur_en = 1;
        start = 1; t_launch = cyc;
        push_run(t_launch + 1, 5, NUM, 1);
        @(negedge clk);
        start = 0;
        repeat (30) @(negedge clk);
        start = 1;
        repeat (5) @(negedge clk);
        start = 0;
        wait_drain(400, "run_a_complete");
        spur_en = 0;
        repeat (3) @(negedge clk);

        // run B: N=1, start held high for two back-to-back runs
        n_lat = 1;
        start = 1; t_launch = cyc;
        push_run(t_launch + 1, 1, NUM, 1);
        push_run(t_launch + 1 + NUM * 4 + 1, 1, NUM, 1);
        dcnt = 0;
        for (int i = 0; i < 400 && dcnt < 2; i++) begin
            @(negedge clk);
            if (i == 20) start = 0;
            if (i == 26) start = 1;
            if (done) begin
                dcnt++;
                if (dcnt == 2) start = 0;
            end
        end
        chk("run_b_done_count", dcnt, 2);
        wait_drain(20, "run_b_complete");
        repeat (5) @(negedge clk);
        chk("run_b_idle_after", trig_start, 0);

        // run C: N=3, reset in WAIT of angle 7 aborts the run
        n_lat = 3;
        start = 1; t_launch = cyc;
        push_run(t_launch + 1, 3, 7, 0);
        @(negedge clk);
        start = 0;
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (trig_start && trig_angle == angle_tab[7]) found = 1;
        end
        chk("angle7_launch_seen", found, 1);
        @(negedge clk);
        reset = 1;
        #1;
        chk("abort_we", {cos_we, sin_we}, 0);
        chk("abort_trig_start", trig_start, 0);
        chk("abort_trig_angle", trig_angle, 0);
        chk("abort_done", done, 0);
        chk("abort_addrs", {read_addr, cos_waddr}, 0);
        chk("abort_data", {cos_din, sin_din}, 0);
        chk("abort_pending", exp_q.size(), 0);
        @(negedge clk);
        reset = 0;
        repeat (20) @(negedge clk);
        chk("abort_stays_idle", dut.state_q, 0);
        chk("abort_no_done_pending", done_exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/angle_sincos_wrapper.md
ANGLE_SINCOS_WRAPPER -- requirements
Module: angle_sincos_wrapper

Interface
REQ-001 SHALL have parameter EXP_LEN, default 8, float exponent width.
REQ-002 SHALL have parameter MANTISSA_LEN, default 23, float mantissa width; W = EXP_LEN+MANTISSA_LEN+1.
REQ-003 SHALL have parameter NUM_ANGLE, default 22, number of normalized angles to process; AW = $clog2(NUM_ANGLE).
REQ-004 clock  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start_angle_sincos  in  1  level; sampled only in IDLE; begins a run.
REQ-007 mem_angle_combination_value_read_addr  out  AW  normalized-angle memory read address.
REQ-008 mem_angle_combination_value_data_out  in  W  normalized angle; valid one cycle after read_addr.
REQ-009 trig_start  out  1  one-cycle pulse launching external sin/cos unit.
REQ-010 trig_angle  out  W  angle operand to sin/cos unit; held stable from trig_start until trig_ready.
REQ-011 trig_ready  in  1  one-cycle pulse; trig_cos/trig_sin valid in that cycle.
REQ-012 trig_cos, trig_sin  in  W each  float results.
REQ-013 mem_cos_write_addr, mem_sin_write_addr  out  AW  result memory write addresses (identical value).
REQ-014 mem_cos_data_in, mem_sin_data_in  out  W each  results to write.
REQ-015 mem_cos_write_en, mem_sin_write_en  out  1 each  write strobes (asserted together).
REQ-016 angle_sincos_done  out  1  one-cycle pulse after last angle written.

Function
REQ-017 FSM states SHALL be IDLE, READ, LAUNCH, WAIT, WRITE.
REQ-018 IDLE: index=0, read_addr=0; on start_angle_sincos=1 go to READ next cycle.
REQ-019 READ: drive read_addr=index for one cycle; go to LAUNCH.
REQ-020 LAUNCH: capture data_out into trig_angle, pulse trig_start for exactly one cycle; go to WAIT.
REQ-021 WAIT: on trig_ready=1 capture trig_cos/trig_sin into data_in registers, go to WRITE; else stay (no timeout).
REQ-022 WRITE: assert both write_en for exactly one cycle with write_addr=index; if index==NUM_ANGLE-1 pulse done, go to IDLE; else index+1, go to READ.
REQ-023 Per-angle latency SHALL be 3 + N cycles, N = trig_start-to-trig_ready cycles (N>=1).
REQ-024 trig_ready outside WAIT SHALL be ignored.
REQ-025 start_angle_sincos outside IDLE SHALL be ignored; if still high in IDLE after done, a new run starts.
REQ-026 index SHALL never exceed NUM_ANGLE-1; no wrap-around writes.
REQ-027 write_en and trig_start SHALL never be asserted in the same cycle.
REQ-028 Addresses processed in ascending order 0..NUM_ANGLE-1, each written exactly once per run.

Reset
REQ-029 reset SHALL force IDLE, index=0 and all outputs to 0, asynchronously.
REQ-030 reset mid-run SHALL abort: no further writes, no done pulse; a later trig_ready is ignored.

Structure
REQ-031 Shared package angle_pkg SHALL hold float width constants and the FSM state enum.
REQ-032 No sub-module; the sin/cos unit is external, shared by handshake.

Verification
REQ-033 Angle[0]=0x3F800000 (1.0), model returns cos 0x3F0A5140, sin 0x3F576AA4 after N=5 -> addr 0 written with those values at cycle 8 after READ.
REQ-034 Full run NUM_ANGLE=22, N=1 -> 22 writes at addresses 0..21, done pulses once, 88 cycles after leaving IDLE.
REQ-035 Spurious trig_ready during READ/LAUNCH -> no write, no state change.
REQ-036 reset asserted in WAIT of angle 7 -> outputs 0 within same cycle, no write to addr 7, no done.
REQ-037 start held high continuously -> back-to-back runs, done pulse every run, start toggled mid-run has no effect.
